fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Instruction-fetch sequencer that sits directly upstream of the pc module.
- Drives the pc's INCR_PC, LOAD_PC and value inputs from the instruction word that a synchronous ROM returns at the current pc address.
- Holds the instruction register and issues one-cycle execute strobes to the datapath.
- Sequences fetch, latch and execute per instruction, supports a run/pause control and halts on HALT.

Parameters:
- PC_W, 8, pc / branch-target width; matches the pc module.
- INSTR_W, 16, instruction width; opcode = ir[INSTR_W-1 -: 4], target = ir[PC_W-1:0].
- ROM_LATENCY, 1, cycles from pc change to instr_in valid; legal range 1..7.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- run  in  1  1 = sequence normally; 0 = pause at the start of the next fetch.
- instr_in  in  INSTR_W  ROM read data for the address currently on the pc.
- zero_flag  in  1  datapath zero flag, sampled in EXEC.
- incr_pc  out  1  one-cycle pulse to pc INCR_PC.
- load_pc  out  1  one-cycle pulse to pc LOAD_PC.
- pc_value  out  PC_W  branch target to pc value.
- ir  out  INSTR_W  instruction register.
- exec_en  out  1  one-cycle strobe: datapath executes the op held in ir.
- halted  out  1  high while in HALT.
- state_dbg  out  2  encoded state for the board display.

Behaviour:
- Clock and reset: one clock (clk). RESET is synchronous and active-high and has priority over all other inputs.
- Reset values: state = FETCH, wait counter = 0, ir = 0, halted = 0. incr_pc, load_pc and exec_en = 0, gated by ~RESET even in the reset cycle. pc_value = ir[PC_W-1:0] = 0.
- States: FETCH=0, LATCH=1, EXEC=2, HALT=3 (state_dbg encoding).
- FETCH:
  - On entry the wait counter is cleared.
  - If run=0, stay in FETCH with the counter frozen at 0.
  - If run=1, increment the counter; when counter == ROM_LATENCY-1, go to LATCH.
  - With ROM_LATENCY=1, FETCH lasts exactly 1 cycle while run=1.
- LATCH: ir <= instr_in; go to EXEC. LATCH is never paused.
- EXEC: outputs are combinational on ir; go to FETCH, except HALT goes to HALT. Per opcode:
  - 0x0 NOP: incr_pc=1.
  - 0x1 JMP: load_pc=1.
  - 0x2 JZ: load_pc=zero_flag, incr_pc=~zero_flag.
  - 0x3 JNZ: load_pc=~zero_flag, incr_pc=zero_flag.
  - 0x4-0xE: exec_en=1, incr_pc=1.
  - 0xF HALT: no pc change; next state HALT.
- Output invariants: incr_pc and load_pc are never both high. incr_pc, load_pc and exec_en are 0 outside EXEC. pc_value = ir[PC_W-1:0] at all times.
- HALT: halted=1; stays in HALT until RESET; run is ignored.
- Latency: one instruction takes ROM_LATENCY+2 cycles (3 with the default). The pc updates on the clock edge that ends EXEC.
- Jumps: a jump to its own address loops forever with no special case.
- Wrap-around: pc wrap-around is owned by the pc module; no special handling here.
- Reset mid-operation: RESET asserted in any state returns to FETCH on the next edge with no strobe in that cycle. A partially counted wait is discarded.
- run dropped during multi-cycle FETCH: counter holds its value; resumes counting when run returns to 1.
- Unused ir bits [INSTR_W-5:PC_W] are stored but ignored.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {FETCH, LATCH, EXEC, HALT} (2 bits).
  - opcode localparams OP_NOP, OP_JMP, OP_JZ, OP_JNZ, OP_HALT, plus range bounds OP_EXEC_LO=4, OP_EXEC_HI=14.
  - OPC_W=4.
- Sub-module fetch_decode (combinational):
  - Inputs: opcode and zero_flag.
  - Outputs: incr, load, exec, is_halt.
  - fetch_seq gates these outputs with (state==EXEC && !RESET).

Test Plan:
- Reset, then run=1 with ROM = {0x0000 NOP, 0x4000, 0xF000} -> incr_pc pulses at cycles 3 and 6, exec_en at cycle 6 only, halted=1 from cycle 10; outputs 0 during reset.
- JMP: ir=0x1025 in EXEC -> load_pc=1 and pc_value=0x25 for exactly one cycle, incr_pc=0.
- JZ 0x2040 with zero_flag=1 -> load_pc=1, pc_value=0x40; with zero_flag=0 -> incr_pc=1, load_pc=0. JNZ 0x3040 gives the inverse.
- ROM_LATENCY=3, run=1 -> FETCH lasts 3 cycles, instruction period 5. Dropping run for 2 cycles mid-FETCH extends the period to 7 with the counter held.
- RESET asserted during EXEC of a JMP -> no load_pc pulse in that cycle; next state FETCH; ir=0.
- In HALT, toggling run for 10 cycles -> remains HALT with no strobes; RESET -> FETCH and halted=0 the next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the instruction-fetch sequencer.
package fetch_pkg;
  localparam int OPC_W = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [OPC_W-1:0] OP_NOP     = 4'h0;
  localparam logic [OPC_W-1:0] OP_JMP     = 4'h1;
  localparam logic [OPC_W-1:0] OP_JZ      = 4'h2;
  localparam logic [OPC_W-1:0] OP_JNZ     = 4'h3;
  localparam logic [OPC_W-1:0] OP_EXEC_LO = 4'h4;
  localparam logic [OPC_W-1:0] OP_EXEC_HI = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT    = 4'hF;
endpackage

// File: rtl/fetch_seq_decode.sv
// Opcode decode: pc control, execute request and halt detect (ungated).
module fetch_decode
  import fetch_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  output logic             incr,
  output logic             load,
  output logic             exec,
  output logic             is_halt
);

  always_comb begin
    incr    = 1'b0;
    load    = 1'b0;
    exec    = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_NOP:  incr = 1'b1;
      OP_JMP:  load = 1'b1;
      OP_JZ: begin
        load = zero_flag;
        incr = ~zero_flag;
      end
      OP_JNZ: begin
        load = ~zero_flag;
        incr = zero_flag;
      end
      OP_HALT: is_halt = 1'b1;
      default: begin
        if (opcode >= OP_EXEC_LO && opcode <= OP_EXEC_HI) begin
          exec = 1'b1;
          incr = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: waits out ROM latency, latches the
// instruction, then strobes the pc / datapath for one EXEC cycle.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               zero_flag,
  output logic               incr_pc,
  output logic               load_pc,
  output logic [PC_W-1:0]    pc_value,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_en,
  output logic               halted,
  output logic [1:0]         state_dbg
);

  localparam logic [2:0] LAST_WAIT = 3'(ROM_LATENCY - 1);

  fetch_state_t state;
  logic [2:0]   wait_cnt;
  logic         dec_incr, dec_load, dec_exec, dec_halt;
  logic         active;

  fetch_decode u_decode (
    .opcode    (ir[INSTR_W-1 -: OPC_W]),
    .zero_flag (zero_flag),
    .incr      (dec_incr),
    .load      (dec_load),
    .exec      (dec_exec),
    .is_halt   (dec_halt)
  );

  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= FETCH;
      wait_cnt <= '0;
      ir       <= '0;
      halted   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // A paused fetch keeps its partial count and resumes from it.
          if (run) begin
            if (wait_cnt == LAST_WAIT) begin
              wait_cnt <= '0;
              state    <= LATCH;
            end else begin
              wait_cnt <= wait_cnt + 3'd1;
            end
          end
        end
        LATCH: begin
          ir    <= instr_in;
          state <= EXEC;
        end
        EXEC: begin
          wait_cnt <= '0;
          if (dec_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are suppressed in a reset cycle even when state is still EXEC.
  assign active    = (state == EXEC) && !RESET;
  assign incr_pc   = active && dec_incr;
  assign load_pc   = active && dec_load;
  assign exec_en   = active && dec_exec;
  assign pc_value  = ir[PC_W-1:0];
  assign state_dbg = state;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq at ROM latencies 1 and 3, each with its own pc and
// pipelined ROM, checked against an instruction-position model.
module tb_fetch_seq;
  localparam int NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, zf;
  logic [15:0] instr [NDUT];
  logic        incr  [NDUT];
  logic        load  [NDUT];
  logic        exe   [NDUT];
  logic        hlt   [NDUT];
  logic [7:0]  pcv   [NDUT];
  logic [15:0] irq   [NDUT];
  logic [1:0]  sdbg  [NDUT];

  fetch_seq #(.PC_W(8), .INSTR_W(16), .ROM_LATENCY(1)) dut_l1 (
    .clk(clk), .RESET(rst), .run(run), .instr_in(instr[0]), .zero_flag(zf),
    .incr_pc(incr[0]), .load_pc(load[0]), .pc_value(pcv[0]), .ir(irq[0]),
    .exec_en(exe[0]), .halted(hlt[0]), .state_dbg(sdbg[0]));

  fetch_seq #(.PC_W(8), .INSTR_W(16), .ROM_LATENCY(3)) dut_l3 (
    .clk(clk), .RESET(rst), .run(run), .instr_in(instr[1]), .zero_flag(zf),
    .incr_pc(incr[1]), .load_pc(load[1]), .pc_value(pcv[1]), .ir(irq[1]),
    .exec_en(exe[1]), .halted(hlt[1]), .state_dbg(sdbg[1]));

  logic [15:0] rom [256];

  // Model: position within the current instruction (0..L-1 fetch, L latch,
  // L+1 exec), plus halt flag, instruction, pc and ROM read pipeline.
  int          mpos  [NDUT];
  bit          mhalt [NDUT];
  logic [15:0] mir   [NDUT];
  logic [7:0]  mpc   [NDUT];
  logic [15:0] pipe  [NDUT][7];

  int  ncmp = 0;
  int  nfail = 0;
  bit  chk_en = 0;
  bit  jmp_reset_done = 0;

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(string tag, int d, logic [15:0] obs, logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, d, $time, obs, exp);
    end
  endtask

  task automatic expect_strobes(int d, output bit ei, output bit el, output bit ee);
    int op;
    ei = 0; el = 0; ee = 0;
    if (!rst && !mhalt[d] && mpos[d] == lat(d) + 1) begin
      op = int'(mir[d][15:12]);
      if (op == 0) ei = 1;
      else if (op == 1) el = 1;
      else if (op == 2) begin el = zf; ei = !zf; end
      else if (op == 3) begin el = !zf; ei = zf; end
      else if (op >= 4 && op <= 14) begin ee = 1; ei = 1; end
    end
  endtask

  // Inputs for this cycle are already set; check, clock, advance model.
  task automatic cycle();
    bit ei [NDUT];
    bit el [NDUT];
    bit ee [NDUT];
    logic [1:0] es;
    for (int d = 0; d < NDUT; d++) instr[d] = pipe[d][lat(d)-1];
    #1;
    for (int d = 0; d < NDUT; d++) begin
      expect_strobes(d, ei[d], el[d], ee[d]);
      if (chk_en) begin
        es = mhalt[d] ? 2'd3 : (mpos[d] < lat(d)) ? 2'd0 : (mpos[d] == lat(d)) ? 2'd1 : 2'd2;
        chk("incr_pc", d, 16'(incr[d]), 16'(ei[d]));
        chk("load_pc", d, 16'(load[d]), 16'(el[d]));
        chk("exec_en", d, 16'(exe[d]), 16'(ee[d]));
        chk("halted", d, 16'(hlt[d]), 16'(mhalt[d]));
        chk("state_dbg", d, 16'(sdbg[d]), 16'(es));
        chk("ir", d, irq[d], mir[d]);
        chk("pc_value", d, 16'(pcv[d]), 16'(mir[d][7:0]));
      end
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 6; k > 0; k--) pipe[d][k] = pipe[d][k-1];
      pipe[d][0] = rom[mpc[d]];
      if (rst) begin
        mpos[d] = 0; mhalt[d] = 0; mir[d] = '0; mpc[d] = '0;
      end else begin
        if (el[d]) mpc[d] = mir[d][7:0];
        else if (ei[d]) mpc[d] = mpc[d] + 8'd1;
        if (mhalt[d]) begin
        end else if (mpos[d] < lat(d)) begin
          if (run) mpos[d]++;
        end else if (mpos[d] == lat(d)) begin
          mir[d] = instr[d];
          mpos[d]++;
        end else if (mir[d][15:12] == 4'hF) begin
          mhalt[d] = 1;
        end else begin
          mpos[d] = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = '0;
    for (int d = 0; d < NDUT; d++) begin
      for (int k = 0; k < 7; k++) pipe[d][k] = '0;
      mpos[d] = 0; mhalt[d] = 0; mir[d] = '0; mpc[d] = '0;
    end
    rst = 1; run = 0; zf = 0;
    @(posedge clk); #1;
    cycle();
    chk_en = 1;

    // NOP, exec op, HALT; then HALT must ignore run until reset.
    rom[0] = 16'h0000; rom[1] = 16'h4000; rom[2] = 16'hF000;
    cycle();
    rst = 0; run = 1;
    repeat (25) cycle();
    repeat (10) begin run = ~run; zf = ~zf; cycle(); end
    rst = 1; cycle();
    rst = 0; run = 1; cycle();

    // Branch program with random run/zero_flag and a reset during a JMP's EXEC.
    rom[0] = 16'h2040; rom[8'h40] = 16'h3050; rom[8'h41] = 16'h1025;
    rom[8'h50] = 16'h1025; rom[8'h51] = 16'h1025;
    rom[8'h25] = 16'h5ABC; rom[8'h26] = 16'h1010; rom[8'h10] = 16'h1010;
    rst = 1; cycle();
    for (int i = 0; i < 400; i++) begin
      run = ($urandom_range(0, 3) != 0);
      zf  = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 39) == 0);
      if (!jmp_reset_done && !mhalt[0] && mpos[0] == 2 && mir[0][15:12] == 4'h1) begin
        rst = 1;
        jmp_reset_done = 1;
      end
      cycle();
    end

    // Fully random program.
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
    rst = 1; cycle();
    for (int i = 0; i < 2000; i++) begin
      run = ($urandom_range(0, 4) != 0);
      zf  = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
